// File: rtl/fos_iir_tdm.sv
// First-order IIR section, time-multiplexed over NCH channels.
// Each accepted sample produces y[n] = x[n-1] - ((a1 * y[n-1]) >>> FRAC)
// for the channel it belongs to, registered one cycle later.
module fos_iir_tdm #(
  parameter  int WIDTH = 32,
  parameter  int FRAC  = 30,
  parameter  int NCH   = 4,
  parameter  int SAT   = 1,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic [CW-1:0]    out_ch,
  input  logic             coef_we,
  input  logic [CW-1:0]    coef_ch,
  input  logic [WIDTH-1:0] coef_data,
  output logic             ovf
);

  // Per-channel history and coefficient storage
  logic signed [WIDTH-1:0] r_x_prev [NCH];
  logic signed [WIDTH-1:0] r_y_prev [NCH];
  logic signed [WIDTH-1:0] r_a1     [NCH];

  logic [CW-1:0]    r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y_out;
  logic [CW-1:0]    r_out_ch;
  logic             r_ovf;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_coef_ok;
  logic [CW-1:0]             w_ptr_next;
  logic signed [WIDTH-1:0]   w_xp;
  logic signed [WIDTH-1:0]   w_yp;
  logic signed [WIDTH-1:0]   w_a1;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH:0]     w_shift;
  logic signed [WIDTH:0]     w_diff;
  logic                      w_over;
  logic [WIDTH-1:0]          w_result;

  assign w_in_ready = !r_out_valid || out_ready;
  // clear overrides acceptance even though in_ready may be high
  assign w_accept   = in_valid && w_in_ready && !clear;
  assign w_coef_ok  = (32'(coef_ch) < 32'(NCH));
  assign w_ptr_next = (r_ptr == CW'(NCH - 1)) ? '0 : r_ptr + 1'b1;

  assign w_xp    = r_x_prev[r_ptr];
  assign w_yp    = r_y_prev[r_ptr];
  assign w_a1    = r_a1[r_ptr];
  assign w_prod  = w_a1 * w_yp;
  assign w_shift = (WIDTH+1)'(w_prod >>> FRAC);
  assign w_diff  = {w_xp[WIDTH-1], w_xp} - w_shift;
  assign w_over  = w_diff[WIDTH] ^ w_diff[WIDTH-1];

  // Clamp to the WIDTH range in saturating mode, otherwise keep the low bits
  always_comb begin
    w_result = w_diff[WIDTH-1:0];
    if ((SAT != 0) && w_over) begin
      w_result = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Channel history update and coefficient writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_x_prev[i] <= '0;
        r_y_prev[i] <= '0;
        r_a1[i]     <= '0;
      end
    end else begin
      if (clear) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          r_x_prev[i] <= '0;
          r_y_prev[i] <= '0;
        end
      end else if (w_accept) begin
        r_x_prev[r_ptr] <= x_in;
        r_y_prev[r_ptr] <= w_result;
      end
      // A same-cycle write to the active channel lands after w_a1 was used
      if (coef_we && w_coef_ok) begin
        r_a1[coef_ch] <= coef_data;
      end
    end
  end

  // Channel pointer, output register and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_y_out     <= '0;
      r_out_ch    <= '0;
      r_ovf       <= 1'b0;
    end else if (clear) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_ptr       <= w_ptr_next;
      r_out_valid <= 1'b1;
      r_y_out     <= w_result;
      r_out_ch    <= r_ptr;
      if (w_over) begin
        r_ovf <= 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y_out     = r_y_out;
  assign out_ch    = r_out_ch;
  assign ovf       = r_ovf;

endmodule

// File: doc/fos_iir_tdm.md
FOS_IIR_TDM -- requirements
Module: fos_iir_tdm

Interface
REQ-001 Parameter WIDTH, default 32, sample/coefficient width in bits, two's complement.
REQ-002 Parameter FRAC, default 30, coefficient fractional bits (a1 in Q(WIDTH-FRAC).FRAC), 0 < FRAC < WIDTH.
REQ-003 Parameter NCH, default 4, number of time-multiplexed channels, NCH >= 1.
REQ-004 Parameter SAT, default 1: 1 = saturate result to WIDTH; 0 = wrap (drop MSBs).
REQ-005 Derived CW = max(1, ceil(log2(NCH))).
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 clear  in  1  synchronous flush of all channel state, coefficients retained.
REQ-009 in_valid  in  1  x_in holds a sample for the current channel.
REQ-010 in_ready  out  1  block accepts a sample this cycle.
REQ-011 x_in  in  WIDTH  input sample, signed.
REQ-012 out_valid  out  1  y_out/out_ch hold a result.
REQ-013 out_ready  in  1  downstream accepts the result this cycle.
REQ-014 y_out  out  WIDTH  filtered sample, signed.
REQ-015 out_ch  out  CW  channel index of y_out.
REQ-016 coef_we  in  1  coefficient write strobe.
REQ-017 coef_ch  in  CW  channel addressed by coef_we.
REQ-018 coef_data  in  WIDTH  new a1 value, signed.
REQ-019 ovf  out  1  sticky overflow flag.

Function
REQ-020 Per channel c, the block SHALL compute y[n] = x[n-1] - ((a1[c] * y[n-1]) >>> FRAC), where x[n-1], y[n-1] are the previous accepted input and previous result of that channel.
REQ-021 Product SHALL be full 2*WIDTH signed, arithmetic right shift by FRAC (floor), subtraction in WIDTH+1 bits before saturation/wrap.
REQ-022 SAT=1: results above 2^(WIDTH-1)-1 or below -2^(WIDTH-1) SHALL clamp to those limits; SAT=0: low WIDTH bits kept.
REQ-023 ovf SHALL set on any accepted sample whose WIDTH+1-bit result is out of WIDTH range (either SAT mode) and stay set until reset or clear.
REQ-024 A sample is accepted when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-025 Channel pointer SHALL start at 0, advance by 1 per accepted sample, wrap from NCH-1 to 0; it does not advance without acceptance.
REQ-026 Latency SHALL be 1 cycle: sample accepted at edge t gives out_valid=1 with y_out, out_ch after edge t; full throughput one sample per cycle when out_ready=1.
REQ-027 While out_valid && !out_ready, y_out, out_ch, out_valid SHALL hold stable and no sample is accepted.
REQ-028 out_valid SHALL clear on out_ready when no new sample is accepted the same cycle.
REQ-029 On acceptance, x_prev[c] <= x_in and y_prev[c] <= the stored (saturated/wrapped) result.
REQ-030 coef_we SHALL update a1[coef_ch] at the edge; coef_ch >= NCH ignored.
REQ-031 Coefficient write to the channel accepting a sample in the same cycle: sample SHALL use the old coefficient.
REQ-032 clear SHALL zero all x_prev, y_prev, channel pointer, out_valid, ovf; a sample presented with clear is dropped (in_ready may be high but acceptance is overridden).
REQ-033 NCH=1 SHALL behave as a single-channel filter, out_ch constant 0.

Reset
REQ-034 reset SHALL zero all x_prev, y_prev, a1, channel pointer, out_valid, y_out, out_ch, ovf; reset wins over clear, coef_we and acceptance.
REQ-035 Reset mid-stream SHALL discard any pending output; first sample after reset is channel 0 with zero history.

Verification (WIDTH=16, FRAC=14, NCH=4, SAT=1)
REQ-036 Impulse: a1[0]=-8192 (-0.5), ch0 inputs 1000,0,0,0 (other channels 0) -> ch0 outputs 0,1000,500,250; other channels 0.
REQ-037 Saturation: a1[1]=-16384, ch1 inputs 30000,30000,... -> ch1 outputs 0,30000,32767, ovf=1 from that output; SAT=0 rerun gives wrapped -5536.
REQ-038 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> y_out/out_ch stable, in_ready=0, channel pointer frozen, no sample lost on release.
REQ-039 Coefficient collision: coef_we to ch2 in cycle ch2 sample accepted -> that result uses old a1, next ch2 sample uses new.
REQ-040 Reset/clear mid-stream: assert after 6 accepted samples -> out_valid=0 next cycle, next output out_ch=0 with y_out=0; after clear coefficients unchanged, after reset all zero.
